intc_im2: RTL

INTC_IM2 -- requirements
Module: intc_im2

---
 rtl/intc_im2_if.sv | 9 +
 rtl/intc_im2.sv | 118 +++++++++++
 2 files changed

// File: rtl/intc_im2_if.sv
// cpu_bus: Z80 bus signals watched by the IM2 interrupt controller
interface cpu_bus;
    logic       m1;
    logic       mreq;
    logic       iorq;
    logic       rd;
    logic [7:0] d;
    modport mon (input m1, mreq, iorq, rd, d);
endinterface

// File: rtl/intc_im2.sv
// intc_im2: Z80 IM2 interrupt controller, fixed priority (bit 0 highest); define INTC_RETI_EN for RETI-tracked nesting
module intc_im2 #(
    parameter int NSRC = 4
) (
    input  logic            clk28,
    input  logic            rst_n,
    cpu_bus.mon             bus,
    input  logic            clkcpu_ck,
    input  logic [NSRC-1:0] irq,
    input  logic [NSRC-1:0] irq_mask,
    input  logic [7:0]      vec_base,
    output logic            n_int,
    output logic            int_vector_rd,
    output logic [7:0]      int_vector_data,
    output logic [NSRC-1:0] in_service
);
    logic [NSRC-1:0] pending_q, pending_d, set_oh;
    logic [2:0]      ack_id_q, ack_id_d, win, isv_low;
    logic            valid_q, valid_d, ack_prev_q, n_int_q, n_int_d;
    logic            ack, ack_first, win_vld, isv_any, eligible, take;
    logic            unused_vec;

    assign unused_vec = ^vec_base[3:0];

    // priority pick: lowest pending source and lowest in-service source
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        isv_low = '0;
        isv_any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win     = 3'(i);
                win_vld = 1'b1;
            end
            if (in_service[i]) begin
                isv_low = 3'(i);
                isv_any = 1'b1;
            end
        end
    end

    // acknowledge decode, pending update (new request wins over ack clear), /INT timing
    always_comb begin
        eligible  = win_vld & (~isv_any | (win < isv_low));
        ack       = bus.iorq & bus.m1;
        ack_first = ack & ~ack_prev_q;
        take      = ack_first & eligible;
        set_oh    = take ? (NSRC'(1) << win) : '0;
        pending_d = ((pending_q & ~set_oh) | irq) & irq_mask;
        ack_id_d  = take ? win : ack_id_q;
        valid_d   = ack_first ? eligible : valid_q;
        n_int_d   = clkcpu_ck ? ~eligible : n_int_q;
    end

    // core controller state
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            ack_id_q   <= '0;
            valid_q    <= 1'b0;
            ack_prev_q <= 1'b0;
            n_int_q    <= 1'b1;
        end else begin
            pending_q  <= pending_d;
            ack_id_q   <= ack_id_d;
            valid_q    <= valid_d;
            ack_prev_q <= ack;
            n_int_q    <= n_int_d;
        end
    end

    assign n_int           = n_int_q;
    assign int_vector_rd   = ack;
    assign int_vector_data = valid_q ? {vec_base[7:4], ack_id_q, 1'b0} : 8'hFF;

`ifdef INTC_RETI_EN
    typedef enum logic [1:0] {IDLE, GOT_ED, DONE} reti_e;
    reti_e           state_q, state_d;
    logic [NSRC-1:0] in_service_q, in_service_d, clr_oh;
    logic [7:0]      op_q, op_d;
    logic            fetch, fetch_prev_q, fall;

    // RETI (ED 4D) detection on opcode bytes captured at the end of each M1 fetch
    always_comb begin
        fetch        = bus.m1 & bus.mreq & bus.rd;
        fall         = fetch_prev_q & ~fetch;
        op_d         = fetch ? bus.d : op_q;
        state_d      = (state_q == DONE) ? IDLE :
                       !fall ? state_q :
                       (op_q == 8'hED) ? GOT_ED :
                       (state_q == GOT_ED && op_q == 8'h4D) ? DONE : IDLE;
        clr_oh       = (state_q == DONE && isv_any) ? (NSRC'(1) << isv_low) : '0;
        in_service_d = (in_service_q & ~clr_oh) | set_oh;
    end

    // RETI tracker and in-service bitmap
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_service_q <= '0;
            op_q         <= '0;
            fetch_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_service_q <= in_service_d;
            op_q         <= op_d;
            fetch_prev_q <= fetch;
        end
    end

    assign in_service = in_service_q;
`else
    logic unused_bus;
    assign unused_bus = ^{bus.mreq, bus.rd, bus.d, set_oh[0]};
    assign in_service = '0;
`endif
endmodule
